// File: rtl/flash_master_if.sv
// Request/response and Avalon-MM (data + CSR) signal bundle for the flash master.
// The master modport is the flash_master view; slave is the requester/flash side.
interface flash_master_if;
  logic        req_read;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_count;
  logic [31:0] req_wdata;
  logic        busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        error;

  logic [15:0] avmm_data_addr;
  logic        avmm_data_read;
  logic        avmm_data_write;
  logic [31:0] avmm_data_writedata;
  logic [1:0]  avmm_data_burstcount;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_waitrequest;
  logic        avmm_data_readdatavalid;

  logic        avmm_csr_addr;
  logic        avmm_csr_read;
  logic        avmm_csr_write;
  logic [31:0] avmm_csr_writedata;
  logic [31:0] avmm_csr_readdata;

  modport master (
    input  req_read, req_write, req_addr, req_count, req_wdata,
    output busy, rd_data, rd_valid, done, error,
    output avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
    output avmm_data_burstcount,
    input  avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid,
    output avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    input  avmm_csr_readdata
  );

  modport slave (
    output req_read, req_write, req_addr, req_count, req_wdata,
    input  busy, rd_data, rd_valid, done, error,
    input  avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
    input  avmm_data_burstcount,
    output avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid,
    input  avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    output avmm_csr_readdata
  );
endinterface

// File: rtl/flash_master.sv
// On-chip flash master: burst reads (2 words per burst max) and single-word writes
// wrapped in CSR unlock / status polling / relock.
module flash_master #(
  parameter logic [31:0] CTRL_UNLOCK = 32'hF07FFFFF,
  parameter logic [31:0] CTRL_LOCK   = 32'hFFFFFFFF,
  parameter logic [15:0] POLL_LIMIT  = 16'd65535
) (
  input logic            clock,
  input logic            reset_n,
  flash_master_if.master bus_io
);

  typedef enum logic [3:0] {
    StIdle, StRdCmd, StRdData, StWrUnlock, StWrData,
    StWrPollReq, StWrPollChk, StWrLock, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  remain_q, remain_d;  // 1..256 words still to read
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  burst_q, burst_d;
  logic [1:0]  beats_q, beats_d;
  logic [15:0] polls_q, polls_d;
  logic        error_q, error_d;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  logic [1:0]  burst_now;
  logic [1:0]  beats_inc;
  logic        data_read, data_write, csr_read, csr_write, csr_addr;
  logic [1:0]  burstcount;
  logic [31:0] data_wdata, csr_wdata;
  logic [31:0] status;
  logic        unused_status;

  assign status        = bus_io.avmm_csr_readdata;
  assign unused_status = ^{status[31:4], status[2]};
  assign burst_now     = (remain_q >= 9'd2) ? 2'd2 : 2'd1;
  assign beats_inc     = beats_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    wdata_d    = wdata_q;
    burst_d    = burst_q;
    beats_d    = beats_q;
    polls_d    = polls_q;
    error_d    = error_q;
    data_read  = 1'b0;
    data_write = 1'b0;
    burstcount = 2'd0;
    data_wdata = 32'd0;
    csr_read   = 1'b0;
    csr_write  = 1'b0;
    csr_addr   = 1'b0;
    csr_wdata  = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_read) begin
          addr_d   = bus_io.req_addr;
          remain_d = (bus_io.req_count == 8'd0) ? 9'd256 : {1'b0, bus_io.req_count};
          error_d  = 1'b0;
          state_d  = StRdCmd;
        end else if (bus_io.req_write) begin
          addr_d  = bus_io.req_addr;
          wdata_d = bus_io.req_wdata;
          error_d = 1'b0;
          state_d = StWrUnlock;
        end
      end
      StRdCmd: begin
        data_read  = 1'b1;
        burstcount = burst_now;
        if (!bus_io.avmm_data_waitrequest) begin
          burst_d = burst_now;
          beats_d = 2'd0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (bus_io.avmm_data_readdatavalid) begin
          beats_d = beats_inc;
          if (beats_inc == burst_q) begin
            addr_d   = addr_q + {14'd0, burst_q};
            remain_d = remain_q - {7'd0, burst_q};
            state_d  = (remain_q == {7'd0, burst_q}) ? StDone : StRdCmd;
          end
        end
      end
      StWrUnlock: begin
        csr_write = 1'b1;
        csr_addr  = 1'b1;
        csr_wdata = CTRL_UNLOCK;
        state_d   = StWrData;
      end
      StWrData: begin
        data_write = 1'b1;
        burstcount = 2'd1;
        data_wdata = wdata_q;
        if (!bus_io.avmm_data_waitrequest) begin
          polls_d = 16'd0;
          state_d = StWrPollReq;
        end
      end
      StWrPollReq: begin
        csr_read = 1'b1;
        state_d  = StWrPollChk;
      end
      StWrPollChk: begin
        // Status bits [1:0] non-zero means the flash is still busy.
        if (status[1:0] != 2'b00) begin
          if (polls_q < POLL_LIMIT) begin
            polls_d = polls_q + 16'd1;
            state_d = StWrPollReq;
          end else begin
            error_d = 1'b1;
            state_d = StWrLock;
          end
        end else begin
          error_d = ~status[3];
          state_d = StWrLock;
        end
      end
      StWrLock: begin
        csr_write = 1'b1;
        csr_addr  = 1'b1;
        csr_wdata = CTRL_LOCK;
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      addr_q     <= 16'd0;
      remain_q   <= 9'd0;
      wdata_q    <= 32'd0;
      burst_q    <= 2'd0;
      beats_q    <= 2'd0;
      polls_q    <= 16'd0;
      error_q    <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      wdata_q    <= wdata_d;
      burst_q    <= burst_d;
      beats_q    <= beats_d;
      polls_q    <= polls_d;
      error_q    <= error_d;
      rd_valid_q <= (state_q == StRdData) && bus_io.avmm_data_readdatavalid;
      if ((state_q == StRdData) && bus_io.avmm_data_readdatavalid) begin
        rd_data_q <= bus_io.avmm_data_readdata;
      end
    end
  end

  assign bus_io.busy                 = (state_q != StIdle);
  assign bus_io.done                 = (state_q == StDone);
  assign bus_io.error                = error_q;
  assign bus_io.rd_data              = rd_data_q;
  assign bus_io.rd_valid             = rd_valid_q;
  assign bus_io.avmm_data_addr       = addr_q;
  assign bus_io.avmm_data_read       = data_read;
  assign bus_io.avmm_data_write      = data_write;
  assign bus_io.avmm_data_writedata  = data_wdata;
  assign bus_io.avmm_data_burstcount = burstcount;
  assign bus_io.avmm_csr_addr        = csr_addr;
  assign bus_io.avmm_csr_read        = csr_read;
  assign bus_io.avmm_csr_write       = csr_write;
  assign bus_io.avmm_csr_writedata   = csr_wdata;

endmodule

// File: tb/tb_flash_master.sv
// Bench for flash_master: Avalon data/CSR slave models, a transaction log, a
// table of directed cases, randomized transactions and a mid-read reset.
module tb_flash_master;
  localparam int unsigned LIMIT   = 4;
  localparam logic [31:0] UNLOCK  = 32'hF07FFFFF;
  localparam logic [31:0] LOCK    = 32'hFFFFFFFF;
  localparam logic [1:0]  OP_RD   = 2'd0;
  localparam logic [1:0]  OP_WR   = 2'd1;
  localparam logic [1:0]  OP_CW   = 2'd2;
  localparam logic [1:0]  OP_CR   = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [1:0]  burst;
    logic [31:0] data;
  } op_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  cnt;
    logic [31:0] wdata;
    int unsigned wt;
    int unsigned nbusy;
    logic [7:0]  bval;
    logic [7:0]  fin;
    int unsigned exp_bursts;
    int unsigned exp_polls;
    bit          exp_err;
    int unsigned exp_cyc;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  flash_master_if bus ();

  flash_master #(.POLL_LIMIT(16'd4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  int unsigned total = 0;
  int unsigned bad = 0;

  // Slave configuration, written only by the main process.
  int unsigned wait_cfg = 0;
  int unsigned cur_nbusy = 0;
  logic [7:0]  cur_bval = 8'h01;
  logic [7:0]  cur_fin = 8'h08;
  bit          gap_en = 1'b0;

  function automatic logic [31:0] mem(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a + 16'd7};
  endfunction

  function automatic logic [7:0] stat_of(input int unsigned i, input int unsigned nb,
                                         input logic [7:0] bv, input logic [7:0] fin);
    return (i < nb) ? bv : fin;
  endfunction

  // ---------------- data slave ----------------
  int unsigned hold_cnt;
  logic        rdv;
  logic [31:0] rdd;
  logic [15:0] pend[$];
  assign bus.avmm_data_waitrequest   = (bus.avmm_data_read || bus.avmm_data_write) &&
                                       (hold_cnt < wait_cfg);
  assign bus.avmm_data_readdatavalid = rdv;
  assign bus.avmm_data_readdata      = rdd;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= 0;
      rdv      <= 1'b0;
      rdd      <= 32'd0;
      pend.delete();
    end else begin
      rdv <= 1'b0;
      if (bus.avmm_data_read || bus.avmm_data_write) begin
        if (bus.avmm_data_waitrequest) hold_cnt <= hold_cnt + 1;
        else begin
          hold_cnt <= 0;
          if (bus.avmm_data_read)
            for (int i = 0; i < int'(bus.avmm_data_burstcount); i++)
              pend.push_back(bus.avmm_data_addr + 16'(i));
        end
      end
      if (pend.size() > 0 && !(gap_en && ($urandom_range(0, 1) == 1))) begin
        rdv <= 1'b1;
        rdd <= mem(pend.pop_front());
      end
    end
  end

  // ---------------- CSR slave (read latency 1) ----------------
  logic [31:0] csr_rdata;
  int unsigned poll_idx;
  assign bus.avmm_csr_readdata = csr_rdata;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csr_rdata <= 32'd0;
      poll_idx  <= 0;
    end else begin
      if (bus.avmm_csr_write && bus.avmm_csr_addr && bus.avmm_csr_writedata == UNLOCK)
        poll_idx <= 0;
      if (bus.avmm_csr_read) begin
        csr_rdata <= {24'hABCDE0, stat_of(poll_idx, cur_nbusy, cur_bval, cur_fin)};
        poll_idx  <= poll_idx + 1;
      end
    end
  end

  // ---------------- monitor (mid-cycle sampling) ----------------
  op_t         log_q[$];
  logic [31:0] words_q[$];
  int unsigned done_cnt = 0, overlap_cnt = 0, stab_cnt = 0, cyc_cnt = 0;
  bit          err_at_done = 1'b0;
  bit          prev_hold = 1'b0;
  logic [51:0] prev_cmd = '0;

  always @(negedge clock) begin
    if (!reset_n) prev_hold <= 1'b0;
    else begin
      if (bus.avmm_data_read && bus.avmm_data_write) overlap_cnt <= overlap_cnt + 1;
      else if ((bus.avmm_data_read || bus.avmm_data_write) &&
               (bus.avmm_csr_read || bus.avmm_csr_write)) overlap_cnt <= overlap_cnt + 1;
      if (bus.avmm_data_read || bus.avmm_data_write) cyc_cnt <= cyc_cnt + 1;
      if (prev_hold && prev_cmd != {bus.avmm_data_read, bus.avmm_data_write,
          bus.avmm_data_addr, bus.avmm_data_burstcount, bus.avmm_data_writedata})
        stab_cnt <= stab_cnt + 1;
      prev_hold <= (bus.avmm_data_read || bus.avmm_data_write) && bus.avmm_data_waitrequest;
      prev_cmd  <= {bus.avmm_data_read, bus.avmm_data_write, bus.avmm_data_addr,
                    bus.avmm_data_burstcount, bus.avmm_data_writedata};
      if ((bus.avmm_data_read || bus.avmm_data_write) && !bus.avmm_data_waitrequest)
        log_q.push_back({bus.avmm_data_read ? OP_RD : OP_WR, bus.avmm_data_addr,
                         bus.avmm_data_burstcount,
                         bus.avmm_data_write ? bus.avmm_data_writedata : 32'd0});
      if (bus.avmm_csr_write)
        log_q.push_back({OP_CW, 15'd0, bus.avmm_csr_addr, 2'd0, bus.avmm_csr_writedata});
      if (bus.avmm_csr_read) log_q.push_back({OP_CR, 15'd0, bus.avmm_csr_addr, 2'd0, 32'd0});
      if (bus.rd_valid) words_q.push_back(bus.rd_data);
      if (bus.done) begin
        done_cnt    <= done_cnt + 1;
        err_at_done <= bus.error;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {bus.busy, bus.done, bus.error, bus.rd_valid, bus.avmm_data_read,
        bus.avmm_data_write, bus.avmm_csr_read, bus.avmm_csr_write, bus.avmm_csr_addr,
        bus.avmm_data_burstcount}, 64'd0);
    chk({tag, "_rd_data"}, bus.rd_data, 64'd0);
    chk({tag, "_addr"}, bus.avmm_data_addr, 64'd0);
    chk({tag, "_wdata"}, {bus.avmm_data_writedata, bus.avmm_csr_writedata}, 64'd0);
  endtask

  op_t         exp_ops[$];
  logic [31:0] exp_words[$];

  task automatic run_txn(input bit wr, input logic [15:0] a, input logic [7:0] c,
                         input logic [31:0] d, input int unsigned wt, input int unsigned nb,
                         input logic [7:0] bv, input logic [7:0] fin, input bit both,
                         input bit poke, input bit gaps, output int unsigned o_bursts,
                         output int unsigned o_polls, output bit o_err,
                         output int unsigned o_cyc);
    int unsigned lbase, wbase, dbase, obase, sbase, cbase, k, rem, n;
    logic [15:0] ma;
    logic [7:0]  st;
    bit          m_err, stop;
    // Reference: expected bus operations and returned words.
    exp_ops.delete();
    exp_words.delete();
    m_err = 1'b0;
    if (!wr) begin
      rem = (c == 8'd0) ? 256 : int'(c);
      for (int i = 0; i < int'(rem); i++) exp_words.push_back(mem(a + 16'(i)));
      ma = a;
      while (rem > 0) begin
        n = (rem >= 2) ? 2 : 1;
        exp_ops.push_back({OP_RD, ma, 2'(n), 32'd0});
        ma  = ma + 16'(n);
        rem = rem - n;
      end
    end else begin
      exp_ops.push_back({OP_CW, 16'd1, 2'd0, UNLOCK});
      exp_ops.push_back({OP_WR, a, 2'd1, d});
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        st = stat_of(n, nb, bv, fin);
        n++;
        exp_ops.push_back({OP_CR, 16'd0, 2'd0, 32'd0});
        if (st[1:0] == 2'b00) begin m_err = ~st[3]; stop = 1'b1; end
        else if (n - 1 >= LIMIT) begin m_err = 1'b1; stop = 1'b1; end
      end
      exp_ops.push_back({OP_CW, 16'd1, 2'd0, LOCK});
    end

    wait_cfg = wt; cur_nbusy = nb; cur_bval = bv; cur_fin = fin; gap_en = gaps;
    lbase = log_q.size(); wbase = words_q.size(); dbase = done_cnt;
    obase = overlap_cnt; sbase = stab_cnt; cbase = cyc_cnt;

    @(negedge clock);
    bus.req_read = ~wr; bus.req_write = wr | both;
    bus.req_addr = a; bus.req_count = c; bus.req_wdata = d;
    @(negedge clock);
    bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = ~a; bus.req_count = ~c; bus.req_wdata = ~d;
    if (poke) begin
      repeat (2) @(negedge clock);
      if (bus.busy) begin
        bus.req_read = 1'b1; bus.req_write = 1'b1;
        @(negedge clock);
        bus.req_read = 1'b0; bus.req_write = 1'b0;
      end
    end
    k = 0;
    while (done_cnt == dbase && k < 6000) begin @(posedge clock); k++; end
    chk("done_seen", done_cnt != dbase, 1);
    @(negedge clock);
    chk("done_once", done_cnt - dbase, 1);
    chk("idle_after", bus.busy, 0);
    chk("err_at_done", err_at_done, m_err);
    chk("err_held", bus.error, m_err);
    chk("no_overlap", overlap_cnt - obase, 0);
    chk("cmd_stable", stab_cnt - sbase, 0);
    chk("op_count", log_q.size() - lbase, exp_ops.size());
    for (int i = 0; i < exp_ops.size() && lbase + i < log_q.size(); i++)
      chk($sformatf("op[%0d]", i), log_q[lbase + i], exp_ops[i]);
    chk("word_count", words_q.size() - wbase, exp_words.size());
    for (int i = 0; i < exp_words.size() && wbase + i < words_q.size(); i++)
      chk($sformatf("word[%0d]", i), words_q[wbase + i], exp_words[i]);
    o_bursts = 0; o_polls = 0;
    for (int i = lbase; i < log_q.size(); i++) begin
      if (log_q[i].op == OP_RD) o_bursts++;
      if (log_q[i].op == OP_CR) o_polls++;
    end
    o_err = err_at_done;
    o_cyc = cyc_cnt - cbase;
  endtask

  function automatic vec_t mk(input bit wr, input logic [15:0] a, input logic [7:0] c,
                              input logic [31:0] d, input int unsigned wt,
                              input int unsigned nb, input logic [7:0] bv,
                              input logic [7:0] fin, input int unsigned eb,
                              input int unsigned ep, input bit ee, input int unsigned ec);
    vec_t v;
    v.wr = wr; v.addr = a; v.cnt = c; v.wdata = d; v.wt = wt; v.nbusy = nb;
    v.bval = bv; v.fin = fin; v.exp_bursts = eb; v.exp_polls = ep; v.exp_err = ee;
    v.exp_cyc = ec;
    return v;
  endfunction

  initial begin
    vec_t        vecs[10];
    int unsigned ob, op, oc, k, lbase;
    bit          oe;
    vecs[0] = mk(0, 16'h0010, 8'd3, 0, 0, 0, 0, 0, 2, 0, 0, 2);
    vecs[1] = mk(0, 16'hFFFF, 8'd2, 0, 5, 0, 0, 0, 1, 0, 0, 6);
    vecs[2] = mk(0, 16'hFFFF, 8'd3, 0, 1, 0, 0, 0, 2, 0, 0, 4);
    vecs[3] = mk(0, 16'hFF80, 8'd0, 0, 0, 0, 0, 0, 128, 0, 0, 128);
    vecs[4] = mk(1, 16'h0123, 0, 32'hA5A5_5A5A, 0, 3, 8'h01, 8'h08, 0, 4, 0, 1);
    vecs[5] = mk(1, 16'h0200, 0, 32'h1234_5678, 2, 1, 8'h03, 8'h00, 0, 2, 1, 3);
    vecs[6] = mk(1, 16'h0300, 0, 32'hDEAD_BEEF, 0, 10, 8'h02, 8'h08, 0, 5, 1, 1);
    vecs[7] = mk(1, 16'hFFFF, 0, 32'h0F0F_0F0F, 0, 0, 8'h01, 8'h0C, 0, 1, 0, 1);
    vecs[8] = mk(0, 16'h8000, 8'd1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[9] = mk(1, 16'h4444, 0, 32'h0000_0001, 1, 2, 8'h01, 8'h04, 0, 3, 1, 2);

    bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = '0; bus.req_count = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_zero("post_reset");

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].cnt, vecs[i].wdata, vecs[i].wt,
              vecs[i].nbusy, vecs[i].bval, vecs[i].fin, 1'b0, 1'b0, 1'b0, ob, op, oe, oc);
      chk($sformatf("vec%0d_bursts", i), ob, vecs[i].exp_bursts);
      chk($sformatf("vec%0d_polls", i), op, vecs[i].exp_polls);
      chk($sformatf("vec%0d_error", i), oe, vecs[i].exp_err);
      chk($sformatf("vec%0d_cmd_cycles", i), oc, vecs[i].exp_cyc);
    end

    for (int t = 0; t < 40; t++) begin
      bit          wr;
      logic [7:0]  c;
      wr = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      run_txn(wr, 16'($urandom), c, $urandom, $urandom_range(0, 3), $urandom_range(0, 6),
              8'($urandom_range(1, 3)), 8'($urandom), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ob, op, oe, oc);
    end

    // Reset in the middle of a read burst, then a clean read.
    wait_cfg = 0; gap_en = 1'b1;
    lbase = log_q.size();
    @(negedge clock);
    bus.req_read = 1'b1; bus.req_addr = 16'h0100; bus.req_count = 8'd6;
    @(negedge clock);
    bus.req_read = 1'b0;
    k = 0;
    while (log_q.size() == lbase && k < 50) begin @(posedge clock); k++; end
    chk("rst_read_issued", log_q.size() > lbase, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (3) @(negedge clock);
    check_zero("held_reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_zero("released");
    run_txn(1'b0, 16'h0200, 8'd5, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, ob, op, oe, oc);
    chk("after_rst_bursts", ob, 3);
    chk("after_rst_error", oe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
